pipelined_carry_select_adder: RTL and testbench

PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

---
 rtl/pipelined_carry_select_adder.sv | 186 ++++++++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_select_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Purpose:
//   WIDTH-bit adder split into L = WIDTH/(SEG*SEGS_PER_STAGE) pipeline
//   stages. Each stage handles SEGS_PER_STAGE segments of SEG bits. Every
//   segment computes its sum for carry-in 0 and 1 at the same time. The
//   carry arriving at the segment then selects one of the two sums. The carry
//   between stages is registered. Operand bits not yet used travel forward
//   with the stage (skew). Finished sum bits also travel forward (deskew), so
//   the whole result leaves the output register aligned.
//   The result appears L cycles after acceptance when there is no
//   back-pressure. Throughput is one result per cycle.
//
// Configuration macro:
//   PIPELINED_CSA_SAT_EN - when defined, sum saturates on signed overflow:
//                          0x7F..F for positive overflow, 0x80..0 for
//                          negative overflow. cout and ovf are raw flags in
//                          both builds, and latency is the same.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   operands present
//   in_ready  out  operands accepted this cycle when in_valid=1
//   in1, in2  in   WIDTH-bit addends
//   cin       in   carry-in
//   out_valid out  result present
//   out_ready in   downstream accepts the result
//   sum       out  WIDTH-bit result
//   cout      out  unsigned carry-out
//   ovf       out  two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipelined_carry_select_adder #(
    parameter int WIDTH          = 32,
    parameter int SEG            = 4,
    parameter int SEGS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Bits handled by one pipeline stage, and the number of stages.
    localparam int SW = SEG * SEGS_PER_STAGE;
    localparam int L  = WIDTH / SW;

    if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_width
        $error("pipelined_carry_select_adder: WIDTH must be a multiple of SEG*SEGS_PER_STAGE");
    end

    // Handshake: a transfer on either side happens on a rising edge where
    // valid and ready are both 1. The whole pipe moves as one shift register.
    // It advances when the output slot is empty or is being drained
    // (en = out_ready | ~out_valid). Input acceptance follows the same enable.
    // So in_ready does not depend on in_valid, and while the output waits for
    // out_ready the sum, cout and ovf outputs are held.
    logic en;

    // Stage input registers. Stage k adds chunk k of a_q[k]/b_q[k] using
    // carry c_q[k]. s_q[k] holds the sum chunks below chunk k, which are
    // already finished.
    logic [L-1:0]     v_q;
    logic [L-1:0]     c_q;
    logic [WIDTH-1:0] a_q [L];
    logic [WIDTH-1:0] b_q [L];
    logic [WIDTH-1:0] s_q [L];

    // Combinational result of each stage: partial sum with chunk k filled in,
    // and the carry out of chunk k.
    logic [WIDTH-1:0] s_w [L];
    logic [L-1:0]     c_w;

    // Output register.
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [SEGS_PER_STAGE:0] seg_c;
        logic [SW-1:0]           part;

        assign seg_c[0] = c_q[k];

        for (genvar j = 0; j < SEGS_PER_STAGE; j++) begin : g_seg
            localparam int LO = k * SW + j * SEG;
            logic [SEG:0] s0;
            logic [SEG:0] s1;

            // Two speculative sums. The carry arriving at the segment only
            // drives the select mux, not the adders.
            assign s0 = {1'b0, a_q[k][LO +: SEG]} + {1'b0, b_q[k][LO +: SEG]};
            assign s1 = {1'b0, a_q[k][LO +: SEG]} + {1'b0, b_q[k][LO +: SEG]}
                        + {{SEG{1'b0}}, 1'b1};

            assign part[j*SEG +: SEG] = seg_c[j] ? s1[SEG-1:0] : s0[SEG-1:0];
            assign seg_c[j+1]         = seg_c[j] ? s1[SEG]     : s0[SEG];
        end

        // Sum bits at and above chunk k are still zero in s_q[k], so OR-ing
        // the new chunk into place is enough.
        assign s_w[k] = s_q[k] | (WIDTH'(part) << (k * SW));
        assign c_w[k] = seg_c[SEGS_PER_STAGE];
    end

    // Final-stage flags. The operand MSBs are still in the last stage's skew
    // registers.
    logic [WIDTH-1:0] raw_sum;
    logic             a_msb;
    logic             b_msb;
    logic             raw_ovf;
    logic [WIDTH-1:0] final_sum;

    assign raw_sum = s_w[L-1];
    assign a_msb   = a_q[L-1][WIDTH-1];
    assign b_msb   = b_q[L-1][WIDTH-1];
    assign raw_ovf = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPELINED_CSA_SAT_EN
    // The operand sign gives the overflow direction. Positive operands
    // saturate to the maximum value, negative operands to the minimum value.
    assign final_sum = raw_ovf ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}})
                               : raw_sum;
`else
    assign final_sum = raw_sum;
`endif

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < L; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            // When in_valid=0 a bubble enters. Its stale data is never
            // marked valid.
            v_q[0] <= in_valid;
            if (in_valid) begin
                a_q[0] <= in1;
                b_q[0] <= in2;
                c_q[0] <= cin;
                s_q[0] <= '0;
            end
            for (int k = 1; k < L; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_w[k-1];
                c_q[k] <= c_w[k-1];
            end
            out_valid_q <= v_q[L-1];
            if (v_q[L-1]) begin
                sum_q  <= final_sum;
                cout_q <= c_w[L-1];
                ovf_q  <= raw_ovf;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
module tb_pipelined_carry_select_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int fails     = 0;

    // {ovf, cout, sum}
    logic [33:0] exp_q[$];

    pipelined_carry_select_adder #(
        .WIDTH(32),
        .SEG(4),
        .SEGS_PER_STAGE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in1(in1),
        .in2(in2),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] t;
        logic        ov;
        logic [31:0] s;
        t  = {1'b0, a} + {1'b0, b} + {32'd0, c};
        ov = (a[31] == b[31]) && (t[31] != a[31]);
        s  = t[31:0];
`ifdef PIPELINED_CSA_SAT_EN
        if (ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, t[32], s};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                            output logic [31:0] s, output logic co, output logic ov,
                            output int lat);
        out_ready = 1'b1;
        in1 = a;
        in2 = b;
        cin = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        s  = sum;
        co = cout;
        ov = ovf;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in1 = 32'h1234_5678;
        in2 = 32'h1111_1111;
        step();
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (sum !== 32'h0) begin fails++; $display("FAIL reset_sum got %h want 00000000", sum); end
        tests_run++;
        if ({cout, ovf} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {cout, ovf}); end
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_ignored_input cycle %0d got out_valid %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_carry_chain();
        logic [31:0] s;
        logic        co, ov;
        int          lat;
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, ov, lat);
        tests_run++;
        if (lat !== 4) begin fails++; $display("FAIL chain_latency got %0d want 4", lat); end
        tests_run++;
        if ({ov, co, s} !== {1'b0, 1'b1, 32'h0000_0000}) begin
            fails++; $display("FAIL chain_result got ovf=%b cout=%b sum=%h want ovf=0 cout=1 sum=00000000", ov, co, s);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [8] = '{32'h0000_000F, 32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
        logic [31:0] tb [8] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
                                32'h0000_0000, 32'h8765_4321, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
        logic        tc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [8] = '{32'h0000_0010, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000,
                                32'h0000_0000, 32'h9999_9999, 32'hFFFF_FFFF, 32'h0000_0000};
        logic        ec [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] s;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            send_one(ta[i], tb[i], tc[i], s, co, ov, lat);
            tests_run++;
            if ({ov, co, s} !== {1'b0, ec[i], es[i]} || lat !== 4) begin
                fails++;
                $display("FAIL boundary_%0d got ovf=%b cout=%b sum=%h lat=%0d want ovf=0 cout=%b sum=%h lat=4",
                         i, ov, co, s, lat, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        logic        co, ov;
        int          lat;
        logic [31:0] exp_pos, exp_neg;
`ifdef PIPELINED_CSA_SAT_EN
        exp_pos = 32'h7FFF_FFFF;
        exp_neg = 32'h8000_0000;
`else
        exp_pos = 32'h8000_0000;
        exp_neg = 32'h7FFF_FFFF;
`endif
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, ov, lat);
        tests_run++;
        if ({ov, co, s} !== {1'b1, 1'b0, exp_pos}) begin
            fails++; $display("FAIL ovf_positive got ovf=%b cout=%b sum=%h want ovf=1 cout=0 sum=%h", ov, co, s, exp_pos);
        end
        send_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, s, co, ov, lat);
        tests_run++;
        if ({ov, co, s} !== {1'b1, 1'b1, exp_neg}) begin
            fails++; $display("FAIL ovf_negative got ovf=%b cout=%b sum=%h want ovf=1 cout=1 sum=%h", ov, co, s, exp_neg);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                32'h1357_9BDF, 32'h8000_0000, 32'hAAAA_AAAA, 32'h0000_FFFF};
        logic [31:0] tb [8] = '{32'h0000_0002, 32'h0123_4567, 32'h0000_0001, 32'h0000_0001,
                                32'h2468_ACE0, 32'h8000_0000, 32'h5555_5555, 32'hFFFF_0000};
        logic        tc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int          got = 0;
        int          first = -1;
        int          last = -1;
        logic [33:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) begin
                in1 = ta[cyc];
                in2 = tb[cyc];
                cin = tc[cyc];
                in_valid = 1'b1;
                exp_q.push_back(model(ta[cyc], tb[cyc], tc[cyc]));
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid === 1'b1) begin
                got++;
                if (first < 0) first = cyc;
                last = cyc;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra got result sum=%h want no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        fails++; $display("FAIL b2b_result_%0d got %h want %h", got - 1, {ovf, cout, sum}, e);
                    end
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (got !== 8 || (last - first) !== 7) begin
            fails++; $display("FAIL b2b_consecutive got count=%0d span=%0d want count=8 span=7", got, last - first);
        end
        tests_run++;
        if (first !== 4) begin fails++; $display("FAIL b2b_first_cycle got %0d want 4", first); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ta [5] = '{32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0F00_00F0, 32'h1234_0000};
        logic [31:0] tb [5] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h00FF_FF10, 32'h0000_5678};
        logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int          k = 0;
        int          guard = 0;
        int          got = 0;
        logic [31:0] held;
        logic [33:0] e;
        exp_q.delete();
        out_ready = 1'b0;
        while (k < 5 && guard < 20) begin
            if (in_ready === 1'b1) begin
                in1 = ta[k];
                in2 = tb[k];
                cin = tc[k];
                in_valid = 1'b1;
                exp_q.push_back(model(ta[k], tb[k], tc[k]));
                k++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || k !== 5) begin
            fails++; $display("FAIL bp_fill got out_valid=%b accepted=%0d want out_valid=1 accepted=5", out_valid, k);
        end
        held = sum;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== held) begin
                fails++; $display("FAIL bp_hold_%0d got in_ready=%b out_valid=%b sum=%h want 0 1 %h",
                                  i, in_ready, out_valid, sum, held);
            end
        end
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                tests_run++;
                if ({ovf, cout, sum} !== e) begin
                    fails++; $display("FAIL bp_result_%0d got %h want %h", got - 1, {ovf, cout, sum}, e);
                end
            end
            step();
            guard++;
        end
        step();
        tests_run++;
        if (got !== 5 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drain got count=%0d out_valid=%b want count=5 out_valid=0", got, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in1 = 32'h0100_0000 * (i + 1);
            in2 = 32'h0000_0003;
            cin = 1'b1;
            in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        in1 = 32'hCAFE_0000;
        in2 = 32'h0000_BABE;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h0) begin
            fails++; $display("FAIL midreset_state got out_valid=%b in_ready=%b sum=%h want 0 1 00000000",
                              out_valid, in_ready, sum);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0) begin
                fails++; $display("FAIL midreset_leak cycle %0d got out_valid=%b sum=%h want out_valid=0", i, out_valid, sum);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_carry_chain();
        test_boundaries();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
